// File: rtl/alu_share_arb_pkg.sv
// alu_share_arb_pkg: shared opcode encodings and helpers for the shared ALU arbiter
package alu_share_arb_pkg;
  localparam int OPW = 4;
  typedef enum logic [OPW-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9
  } alu_op_e;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/alu_share_arb_rr_arb.sv
// rr_arb: combinational round-robin grant, first request at or after ptr_i wins
// ports: req_i request vector, ptr_i search start, gnt_o one-hot grant, gnt_idx_o grant index, any_o grant present
module rr_arb
  import alu_share_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);
  logic [IW-1:0] j;
  // scan from farthest to nearest so the nearest request overwrites the rest
  always_comb begin
    j = '0;
    gnt_idx_o = '0;
    any_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (req_i[j]) begin
        gnt_idx_o = j;
        any_o = 1'b1;
      end
    end
  end
  assign gnt_o = any_o ? N'(1) << gnt_idx_o : '0;
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin share of one RV32 integer ALU with a single registered response slot
// ports: req_valid_i/req_ready_o/req_op_i/req_rs1_i/req_rs2_i per-requester request channel,
//        rsp_valid_o/rsp_ready_i/rsp_id_o/rsp_rd_o/rsp_ill_o response channel, clk, rst_n async active-low
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = 32,
  parameter int IDW  = idx_w(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*OPW-1:0]  req_op_i,
  input  logic [NREQ*XLEN-1:0] req_rs1_i,
  input  logic [NREQ*XLEN-1:0] req_rs2_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IDW-1:0]       rsp_id_o,
  output logic [XLEN-1:0]      rsp_rd_o,
  output logic                 rsp_ill_o
);
  logic            rsp_valid_q, rsp_ill_q, rsp_ill_d, free, gnt_any;
  logic [IDW-1:0]  rsp_id_q, ptr_q, ptr_d, gnt_idx;
  logic [XLEN-1:0] rsp_rd_q, rsp_rd_d, rs1, rs2;
  logic [OPW-1:0]  op;
  logic [4:0]      shamt;
  assign free = !rsp_valid_q || rsp_ready_i;
  // masking requests with free keeps req_ready independent of any payload
  rr_arb #(.N(NREQ), .IW(IDW)) u_arb (
    .req_i     (req_valid_i & {NREQ{free}}),
    .ptr_i     (ptr_q),
    .gnt_o     (req_ready_o),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );
  assign op    = req_op_i[OPW*gnt_idx +: OPW];
  assign rs1   = req_rs1_i[XLEN*gnt_idx +: XLEN];
  assign rs2   = req_rs2_i[XLEN*gnt_idx +: XLEN];
  assign shamt = rs2[4:0];
  assign ptr_d = gnt_idx == IDW'(NREQ - 1) ? '0 : gnt_idx + 1'b1;
  always_comb begin
    rsp_rd_d = '0;
    rsp_ill_d = 1'b0;
    case (op)
      OP_ADD:  rsp_rd_d = rs1 + rs2;
      OP_SUB:  rsp_rd_d = rs1 - rs2;
      OP_SLL:  rsp_rd_d = rs1 << shamt;
      OP_SLT:  rsp_rd_d = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(rs2)};
      OP_SLTU: rsp_rd_d = {{(XLEN-1){1'b0}}, rs1 < rs2};
      OP_XOR:  rsp_rd_d = rs1 ^ rs2;
      OP_SRL:  rsp_rd_d = rs1 >> shamt;
      OP_SRA:  rsp_rd_d = $unsigned($signed(rs1) >>> shamt);
      OP_OR:   rsp_rd_d = rs1 | rs2;
      OP_AND:  rsp_rd_d = rs1 & rs2;
      default: rsp_ill_d = 1'b1;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_rd_q <= '0;
      rsp_ill_q <= 1'b0;
      ptr_q <= '0;
    end else if (gnt_any) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q <= gnt_idx;
      rsp_rd_q <= rsp_rd_d;
      rsp_ill_q <= rsp_ill_d;
      ptr_q <= ptr_d;
    end else if (rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_rd_o    = rsp_rd_q;
  assign rsp_ill_o   = rsp_ill_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: table vectors, directed corner sequences and random traffic against a reference model
module tb_alu_share_arb;
  localparam int NREQ = 2;
  localparam int XLEN = 32;
  localparam int IDW  = 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*4-1:0]    req_op;
  logic [NREQ*XLEN-1:0] req_rs1, req_rs2;
  logic                 rsp_valid, rsp_ready, rsp_ill;
  logic [IDW-1:0]       rsp_id;
  logic [XLEN-1:0]      rsp_rd;
  alu_share_arb #(.NREQ(NREQ), .XLEN(XLEN), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_rs1_i   (req_rs1),
    .req_rs2_i   (req_rs2),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_rd_o    (rsp_rd),
    .rsp_ill_o   (rsp_ill)
  );
  int errors = 0;
  int checks = 0;
  bit m_valid, m_ill;
  int m_id, m_ptr, last_g, req1_wait;
  logic [31:0] m_rd;
  typedef struct {int id; logic [31:0] rd; bit ill;} acc_t;
  acc_t sb[$];
  typedef struct {int id; logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] rd; bit ill;} vec_t;
  vec_t vecs[14];
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output bit ill);
    int s;
    s = int'(b % 32);
    ill = 1'b0;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a * (32'd1 << s);
      4'd3: return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
      4'd4: return (longint'({32'd0, a}) < longint'({32'd0, b})) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return a / (32'd1 << s);
      4'd7: return (a >> s) | (a[31] ? ~(32'hFFFFFFFF >> s) : 32'h0);
      4'd8: return a | b;
      4'd9: return a & b;
      default: begin ill = 1'b1; return 32'd0; end
    endcase
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_valid = 0; m_ill = 0; m_id = 0; m_rd = 0; m_ptr = 0; req1_wait = 0;
    sb.delete();
  endtask
  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[4*i +: 4] = op;
    req_rs1[XLEN*i +: XLEN] = a;
    req_rs2[XLEN*i +: XLEN] = b;
  endtask
  task automatic cycle();
    int g;
    bit free, il;
    logic [31:0] r;
    acc_t a;
    #1;
    free = !m_valid || rsp_ready;
    g = -1;
    if (free)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    check("req_ready", 32'(req_ready), g < 0 ? 32'd0 : 32'd1 << g);
    if (m_valid && rsp_ready) begin
      if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else begin
        a = sb.pop_front();
        check("sb_id", 32'(rsp_id), 32'(a.id));
        check("sb_rd", rsp_rd, a.rd);
        check("sb_ill", 32'(rsp_ill), 32'(a.ill));
      end
    end
    if (g >= 0) begin
      r = ref_alu(req_op[4*g +: 4], req_rs1[XLEN*g +: XLEN], req_rs2[XLEN*g +: XLEN], il);
      sb.push_back('{g, r, il});
      if (g == 1) req1_wait = 0;
      else if (req_valid[1]) begin
        req1_wait++;
        check("req1_wait_bound", 32'(req1_wait <= NREQ - 1), 32'd1);
      end
    end
    last_g = g;
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1; m_id = g; m_rd = r; m_ill = il; m_ptr = (g + 1) % NREQ;
    end else if (rsp_ready) m_valid = 0;
    #1;
    check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check("rsp_id", 32'(rsp_id), 32'(m_id));
    check("rsp_rd", rsp_rd, m_rd);
    check("rsp_ill", 32'(rsp_ill), 32'(m_ill));
  endtask
  task automatic refresh();
    for (int i = 0; i < NREQ; i++)
      if (last_g == i || !req_valid[i]) begin
        req_valid[i] = 1'($urandom_range(0, 1));
        set_req(i, 4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    vecs = '{
      '{0, 4'h3, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0},
      '{0, 4'h4, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0},
      '{0, 4'h3, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0,        1'b0},
      '{0, 4'h0, 32'h2,        32'h1,        32'h3,        1'b0},
      '{1, 4'h1, 32'h1,        32'h2,        32'hFFFFFFFF, 1'b0},
      '{1, 4'hF, 32'h5,        32'h6,        32'h0,        1'b1},
      '{0, 4'h7, 32'h80000000, 32'h4,        32'hF8000000, 1'b0},
      '{0, 4'h2, 32'h1,        32'd33,       32'h2,        1'b0},
      '{1, 4'h6, 32'h80000000, 32'h4,        32'h08000000, 1'b0},
      '{0, 4'h5, 32'hF0F0,     32'hFF00,     32'h0FF0,     1'b0},
      '{1, 4'h8, 32'hF0F0,     32'hFF00,     32'hFFF0,     1'b0},
      '{1, 4'h9, 32'hF0F0,     32'hFF00,     32'hF000,     1'b0},
      '{0, 4'hA, 32'h1,        32'h1,        32'h0,        1'b1},
      '{1, 4'h0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0}
    };
    req_valid = '0; req_op = '0; req_rs1 = '0; req_rs2 = '0; rsp_ready = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("reset_valid", 32'(rsp_valid), 32'd0);
    check("reset_id", 32'(rsp_id), 32'd0);
    check("reset_rd", rsp_rd, 32'd0);
    check("reset_ill", 32'(rsp_ill), 32'd0);
    rst_n = 1'b1;
    foreach (vecs[v]) begin
      req_valid = '0;
      req_valid[vecs[v].id] = 1'b1;
      set_req(vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].b);
      cycle();
      check("vec_rd", rsp_rd, vecs[v].rd);
      check("vec_ill", 32'(rsp_ill), 32'(vecs[v].ill));
      check("vec_id", 32'(rsp_id), 32'(vecs[v].id));
    end
    req_valid = '0;
    cycle();
    req_valid = 2'b11;
    set_req(0, 4'h0, 32'd2, 32'd1);
    set_req(1, 4'h1, 32'd1, 32'd2);
    for (int c = 0; c < 8; c++) begin
      cycle();
      check("b2b_valid", 32'(rsp_valid), 32'd1);
      set_req(last_g, 4'($urandom_range(0, 9)), $urandom, $urandom);
    end
    rsp_ready = 1'b0;
    repeat (3) cycle();
    rsp_ready = 1'b1;
    cycle();
    check("release_grant", 32'(last_g >= 0), 32'd1);
    req_valid = 2'b10;
    for (int c = 0; c < 12; c++) begin
      req_valid[0] = ~req_valid[0];
      cycle();
      if (last_g == 1) set_req(1, 4'($urandom_range(0, 15)), $urandom, $urandom);
    end
    for (int c = 0; c < 400; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      refresh();
      cycle();
    end
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    set_req(0, 4'h0, 32'd7, 32'd8);
    cycle();
    req_valid = 2'b10;
    rsp_ready = 1'b0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_rd", rsp_rd, 32'd0);
    #1;
    rst_n = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    cycle();
    check("post_rst_grant", 32'(last_g), 32'd0);
    req_valid = '0;
    cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
